// File: rtl/double_tokens_pkg.sv
// Shared constants and helpers for the serial token expander.
package double_tokens_pkg;

  localparam int FACTOR_MAX = 8;

  // Width of a counter holding 0..max; a zero-token store still gets one bit.
  function automatic int pending_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/double_tokens_if.sv
// Token stream bundle between a token source (master) and the expander (slave).
// DOUBLE_TOKENS_LEVEL_EN adds the level/hwm occupancy view of width W.
interface double_tokens_if
`ifdef DOUBLE_TOKENS_LEVEL_EN
  #(parameter int W = 4)
`endif
  ;
  logic a;
  logic b;
  logic busy;
  logic overflow;
`ifdef DOUBLE_TOKENS_LEVEL_EN
  logic [W-1:0] level;
  logic [W-1:0] hwm;
`endif

  modport master (
    output a,
`ifdef DOUBLE_TOKENS_LEVEL_EN
    input  level,
    input  hwm,
`endif
    input  b,
    input  busy,
    input  overflow
  );

  modport slave (
    input  a,
`ifdef DOUBLE_TOKENS_LEVEL_EN
    output level,
    output hwm,
`endif
    output b,
    output busy,
    output overflow
  );

endinterface

// File: rtl/double_tokens_token_sat_counter.sv
// Add-N / subtract-1 counter that clamps at MAX and strobes sat when it clamps.
module token_sat_counter
  import double_tokens_pkg::*;
#(
  parameter int MAX    = 15,
  parameter int STEP_W = 4,
  localparam int W     = pending_width(MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STEP_W-1:0] add,
  input  logic              dec,
  output logic [W-1:0]      count,
  output logic [W-1:0]      next,
  output logic              sat
);

  // Four guard bits cover count + add for any add up to FACTOR_MAX.
  localparam int SUM_W = W + 4;

  logic [SUM_W-1:0] sum;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum  = SUM_W'(count) + SUM_W'(add) - SUM_W'(dec);
    sat  = 1'b0;
    next = sum[W-1:0];
    if (sum > SUM_W'(MAX)) begin
      sat  = 1'b1;
      next = W'(MAX);
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= next;
  end

endmodule

// File: rtl/double_tokens.sv
// Serial token expander: each input token yields FACTOR output tokens, one per cycle.
// Optional DOUBLE_TOKENS_LEVEL_EN exposes the pending level and its high-water mark.
module double_tokens
  import double_tokens_pkg::*;
#(
  parameter int FACTOR      = 2,
  parameter int MAX_PENDING = 15
) (
  input  logic           clk,
  input  logic           rst,
  double_tokens_if.slave tok
);

  localparam int W      = pending_width(MAX_PENDING);
  localparam int STEP_W = pending_width(FACTOR_MAX);

  if (FACTOR < 1 || FACTOR > FACTOR_MAX) begin : g_bad_factor
    $error("double_tokens: FACTOR must be in 1..%0d", FACTOR_MAX);
  end
  if (MAX_PENDING < FACTOR - 1) begin : g_bad_max
    $error("double_tokens: MAX_PENDING must be >= FACTOR-1");
  end

  logic [W-1:0]      cnt;
  logic [W-1:0]      cnt_next;
  logic [STEP_W-1:0] add;
  logic              sat;
  logic              b;
  logic              ovf;

  // Zero-latency output: a fresh token passes straight through, backlog fills the gaps.
  assign b   = tok.a | (cnt != '0);
  assign add = tok.a ? STEP_W'(FACTOR) : '0;

  token_sat_counter #(
    .MAX    (MAX_PENDING),
    .STEP_W (STEP_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .add   (add),
    .dec   (b),
    .count (cnt),
    .next  (cnt_next),
    .sat   (sat)
  );

  always_ff @(posedge clk) begin
    if (rst)      ovf <= 1'b0;
    else if (sat) ovf <= 1'b1;
  end

  assign tok.b        = b;
  assign tok.busy     = (cnt != '0);
  assign tok.overflow = ovf;

`ifdef DOUBLE_TOKENS_LEVEL_EN
  logic [W-1:0] hwm;

  // Compared against the incoming count so the peak is visible with level, not a cycle later.
  always_ff @(posedge clk) begin
    if (rst)                 hwm <= '0;
    else if (cnt_next > hwm) hwm <= cnt_next;
  end

  assign tok.level = cnt;
  assign tok.hwm   = hwm;
`else
  logic unused_next;
  assign unused_next = ^cnt_next;
`endif

endmodule

// File: tb/tb_double_tokens.sv
// Directed bench for double_tokens: three instances cover doubling, saturation and FACTOR=3.
module tb_double_tokens;
  import double_tokens_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DOUBLE_TOKENS_LEVEL_EN
  double_tokens_if #(.W(pending_width(15))) m_if ();
  double_tokens_if #(.W(pending_width(4)))  s_if ();
  double_tokens_if #(.W(pending_width(15))) t_if ();
`else
  double_tokens_if m_if ();
  double_tokens_if s_if ();
  double_tokens_if t_if ();
`endif

  double_tokens #(.FACTOR(2), .MAX_PENDING(15)) u_main (.clk(clk), .rst(rst), .tok(m_if.slave));
  double_tokens #(.FACTOR(2), .MAX_PENDING(4))  u_sat  (.clk(clk), .rst(rst), .tok(s_if.slave));
  double_tokens #(.FACTOR(3), .MAX_PENDING(15)) u_f3   (.clk(clk), .rst(rst), .tok(t_if.slave));

  // Expected streams, MSB = first cycle.
  logic [4:0]  t1_a = 5'b11000, t1_b = 5'b11110, t1_busy = 5'b01110;
  logic [4:0]  t2_a = 5'b10100, t2_b = 5'b11110, t2_busy = 5'b01010;
  logic [10:0] t3_a = 11'b11111100000, t3_b = 11'b11111111110;
  logic [10:0] t3_busy = 11'b01111111110, t3_ovf = 11'b00000111111;
  logic [3:0]  t4_a = 4'b1000, t4_b = 4'b1110, t4_busy = 4'b0110;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic am, input logic as, input logic at);
    @(negedge clk);
    rst    = r;
    m_if.a = am;
    s_if.a = as;
    t_if.a = at;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m_if.a = 1'b0; s_if.a = 1'b0; t_if.a = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    check("rst_b",     8'(m_if.b),        8'd0);
    check("rst_busy",  8'(m_if.busy),     8'd0);
    check("rst_ovf",   8'(m_if.overflow), 8'd0);
    check("rst_sat_b", 8'(s_if.busy),     8'd0);
    check("rst_f3_b",  8'(t_if.busy),     8'd0);

    for (int i = 0; i < 5; i++) begin
      drive(0, t1_a[4-i], 0, 0);
      check("t1_b",    8'(m_if.b),        8'(t1_b[4-i]));
      check("t1_busy", 8'(m_if.busy),     8'(t1_busy[4-i]));
      check("t1_ovf",  8'(m_if.overflow), 8'd0);
    end

    for (int i = 0; i < 5; i++) begin
      drive(0, t2_a[4-i], 0, 0);
      check("t2_b",    8'(m_if.b),    8'(t2_b[4-i]));
      check("t2_busy", 8'(m_if.busy), 8'(t2_busy[4-i]));
    end

    for (int i = 0; i < 11; i++) begin
      drive(0, 0, t3_a[10-i], 0);
      check("t3_b",    8'(s_if.b),        8'(t3_b[10-i]));
      check("t3_busy", 8'(s_if.busy),     8'(t3_busy[10-i]));
      check("t3_ovf",  8'(s_if.overflow), 8'(t3_ovf[10-i]));
    end

    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, t4_a[3-i]);
      check("t4_b",    8'(t_if.b),    8'(t4_b[3-i]));
      check("t4_busy", 8'(t_if.busy), 8'(t4_busy[3-i]));
    end

    // Reset mid-drain: three tokens in leave cnt=3 when rst is sampled.
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    check("t5_b_in_rst",    8'(m_if.b),        8'd1);
    check("t5_busy_in_rst", 8'(m_if.busy),     8'd1);
    drive(0, 0, 0, 0);
    check("t5_b_after",     8'(m_if.b),        8'd0);
    check("t5_busy_after",  8'(m_if.busy),     8'd0);
    check("t5_ovf_after",   8'(m_if.overflow), 8'd0);
    check("t5_sat_ovf_clr", 8'(s_if.overflow), 8'd0);

    // A token presented during reset is not counted.
    drive(1, 1, 0, 0);
    check("t6_b_in_rst",   8'(m_if.b),    8'd1);
    drive(0, 0, 0, 0);
    check("t6_busy_after", 8'(m_if.busy), 8'd0);
    check("t6_b_after",    8'(m_if.b),    8'd0);

`ifdef DOUBLE_TOKENS_LEVEL_EN
    begin
      logic [6:0]  lv_a = 7'b1110000;
      logic [27:0] lv_l = {4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
      logic [27:0] lv_h = {4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
      for (int i = 0; i < 7; i++) begin
        drive(0, lv_a[6-i], 0, 0);
        check("lv_level", 8'(m_if.level), 8'(lv_l[(6-i)*4 +: 4]));
        check("lv_hwm",   8'(m_if.hwm),   8'(lv_h[(6-i)*4 +: 4]));
      end
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
      check("lv_hwm_rst", 8'(m_if.hwm), 8'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
